// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Services the core's load (4'b1100) and store (4'b1101)
//               opcodes over a byte-wide req/ack memory bus. Each 16-bit
//               word access is split into two little-endian byte transfers.
//               The core is stalled until the access completes or a byte
//               transfer times out.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   i_start       in   1   core requests an access this cycle
//   i_opcode      in   4   4'b1100 load, 4'b1101 store, others ignored
//   i_address     in   16  word address
//   i_write_data  in   16  store word
//   o_read_data   out  16  last loaded word (registered)
//   o_stall       out  1   core must hold its state
//   o_done        out  1   one-cycle pulse: access finished
//   o_bus_error   out  1   one-cycle pulse with o_done: access timed out
//   o_bus_req     out  1   byte transfer requested
//   o_bus_we      out  1   1 = write byte, 0 = read byte
//   o_bus_addr    out  16  byte address
//   o_bus_wdata   out  8   write byte
//   i_bus_rdata   in   8   read byte, valid with i_bus_ack
//   i_bus_ack     in   1   transfer completes on an edge with req && ack
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [3:0]  i_opcode,
    input  logic [15:0] i_address,
    input  logic [15:0] i_write_data,
    output logic [15:0] o_read_data,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_bus_error,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    input  logic        i_bus_ack
);

    localparam logic [3:0] c_OP_LOAD  = 4'b1100;
    localparam logic [3:0] c_OP_STORE = 4'b1101;

    // Counter must hold TIMEOUT_CYCLES itself: it steps once more on the
    // timeout edge before DONE clears it.
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_BYTE0 = 2'd1;
    localparam logic [1:0] c_S_BYTE1 = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [14:0]        r_addr;        // word address; bit 15 has no byte slot
    logic [15:0]        r_wdata;
    logic               r_is_store;
    logic [7:0]         r_buf_lo;      // low byte of a load awaiting its high byte
    logic [c_CNT_W-1:0] r_tcnt;
    logic [15:0]        r_read_data;
    logic               r_err;

    logic w_valid_op;
    logic w_accept;
    logic w_in_byte;
    logic w_xfer;
    logic w_timeout;
    logic w_unused_addr_msb;

    assign w_unused_addr_msb = i_address[15];

    assign w_valid_op = (i_opcode == c_OP_LOAD) || (i_opcode == c_OP_STORE);
    assign w_accept   = (r_state == c_S_IDLE) && i_start && w_valid_op;
    assign w_in_byte  = (r_state == c_S_BYTE0) || (r_state == c_S_BYTE1);
    assign w_xfer     = w_in_byte && i_bus_ack;
    // A byte state has lasted TIMEOUT_CYCLES cycles when this is its last
    // cycle and still no ack; an ack on that same cycle wins.
    assign w_timeout  = w_in_byte && !i_bus_ack && (r_tcnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_S_BYTE0;
                end
            end
            c_S_BYTE0: begin
                if (w_xfer) begin
                    w_next_state = c_S_BYTE1;
                end else if (w_timeout) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_BYTE1: begin
                if (w_xfer || w_timeout) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_next_state = c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state so reset removes bus_req immediately
    // ------------------------------------------------------------------
    always_comb begin
        o_stall     = w_in_byte || w_accept;
        o_done      = (r_state == c_S_DONE);
        o_bus_error = (r_state == c_S_DONE) && r_err;
        o_bus_req   = w_in_byte;
        o_bus_we    = w_in_byte && r_is_store;
        o_bus_addr  = 16'h0000;
        o_bus_wdata = 8'h00;
        if (w_in_byte) begin
            o_bus_addr = {r_addr, (r_state == c_S_BYTE1)};
            if (r_is_store) begin
                o_bus_wdata = (r_state == c_S_BYTE1) ? r_wdata[15:8] : r_wdata[7:0];
            end
        end
    end

    assign o_read_data = r_read_data;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= 15'h0000;
            r_wdata     <= 16'h0000;
            r_is_store  <= 1'b0;
            r_buf_lo    <= 8'h00;
            r_tcnt      <= '0;
            r_read_data <= 16'h0000;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= i_address[14:0];
                r_wdata    <= i_write_data;
                r_is_store <= (i_opcode == c_OP_STORE);
            end

            if (w_xfer || !w_in_byte) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + c_CNT_ONE;
            end

            if (w_xfer && !r_is_store && (r_state == c_S_BYTE0)) begin
                r_buf_lo <= i_bus_rdata;
            end

            // read_data is written on the edge into DONE so the new word is
            // presented together with the done pulse.
            if (!r_is_store) begin
                if (w_xfer && (r_state == c_S_BYTE1)) begin
                    r_read_data <= {i_bus_rdata, r_buf_lo};
                end else if (w_timeout) begin
                    r_read_data <= 16'h0000;
                end
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_accept) begin
                r_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A byte memory
//               responder drives the bus with chosen wait counts; a word-level
//               reference model predicts bus traffic, latency, error and
//               read_data for each access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int T = 8;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [3:0]  i_opcode;
    logic [15:0] i_address;
    logic [15:0] i_write_data;
    logic [15:0] o_read_data;
    logic        o_stall;
    logic        o_done;
    logic        o_bus_error;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [15:0] o_bus_addr;
    logic [7:0]  o_bus_wdata;
    logic [7:0]  i_bus_rdata;
    logic        i_bus_ack;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_opcode     (i_opcode),
        .i_address    (i_address),
        .i_write_data (i_write_data),
        .o_read_data  (o_read_data),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_bus_error  (o_bus_error),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_ack    (i_bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  bus_mem [0:65535];   // what the responder actually holds
    logic [7:0]  ref_mem [0:65535];   // what memory should hold
    logic [15:0] ref_rd;
    int          n_total;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One word access. Entered and left at posedge+1 with the DUT idle.
    // w0/w1: wait cycles before ack for each byte; >= T means never acked.
    task automatic run_access(input bit is_store, input logic [15:0] addr,
                              input logic [15:0] wd, input int w0, input int w1,
                              input bit noise);
        int          exp_done_cyc;
        bit          exp_err;
        int          exp_xfers;
        logic [15:0] exp_rd;
        logic [15:0] a_lo;
        logic [15:0] a_hi;
        int          b;
        int          k;
        int          xfers;
        bit          got_done;
        int          waits [2];
        logic [7:0]  exp_byte;

        waits[0] = w0;
        waits[1] = w1;
        a_lo = {addr[14:0], 1'b0};
        a_hi = {addr[14:0], 1'b1};

        if (w0 >= T) begin
            exp_done_cyc = 1 + T;
            exp_err      = 1'b1;
            exp_xfers    = 0;
        end else if (w1 >= T) begin
            exp_done_cyc = 2 + w0 + T;
            exp_err      = 1'b1;
            exp_xfers    = 1;
        end else begin
            exp_done_cyc = 3 + w0 + w1;
            exp_err      = 1'b0;
            exp_xfers    = 2;
        end

        if (is_store)     exp_rd = ref_rd;
        else if (exp_err) exp_rd = 16'h0000;
        else              exp_rd = {ref_mem[a_hi], ref_mem[a_lo]};

        // cycle 0
        i_start      = 1'b1;
        i_opcode     = is_store ? 4'b1101 : 4'b1100;
        i_address    = addr;
        i_write_data = wd;
        #1;
        chk("stall_c0", o_stall, 1'b1);
        chk("req_c0", o_bus_req, 1'b0);

        b = 0; k = 0; xfers = 0; got_done = 1'b0;
        for (int cyc = 1; cyc <= exp_done_cyc + 3 && !got_done; cyc++) begin
            @(posedge clk); #1;
            i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                i_opcode     = 4'($urandom_range(12, 13));
                i_address    = 16'($urandom);
                i_write_data = 16'($urandom);
            end
            i_bus_ack   = 1'b0;
            i_bus_rdata = 8'($urandom);
            if (o_done) begin
                got_done = 1'b1;
                chk("done_cycle", cyc, exp_done_cyc);
                chk("bus_error", o_bus_error, exp_err);
                chk("read_data", o_read_data, exp_rd);
                chk("stall_done", o_stall, 1'b0);
                chk("req_done", o_bus_req, 1'b0);
            end else if (b < 2) begin
                chk("stall_busy", o_stall, 1'b1);
                chk("bus_req", o_bus_req, 1'b1);
                chk("bus_addr", o_bus_addr, (b == 1) ? a_hi : a_lo);
                chk("bus_we", o_bus_we, is_store);
                exp_byte = (b == 1) ? wd[15:8] : wd[7:0];
                chk("bus_wdata", o_bus_wdata, is_store ? exp_byte : 8'h00);
                if (k == waits[b]) begin
                    i_bus_ack = 1'b1;
                    if (is_store) bus_mem[o_bus_addr] = o_bus_wdata;
                    else          i_bus_rdata = bus_mem[o_bus_addr];
                    xfers++;
                    b++;
                    k = 0;
                end else begin
                    k++;
                end
            end
        end
        if (!got_done) chk("done_seen", 1'b0, 1'b1);
        chk("xfers", xfers, exp_xfers);

        // idle cycle after DONE: a start held through DONE must not launch
        @(posedge clk); #1;
        i_start   = 1'b0;
        i_bus_ack = 1'b0;
        chk("req_after_done", o_bus_req, 1'b0);
        chk("done_pulse", o_done, 1'b0);

        // reference model update
        if (is_store) begin
            if (w0 < T) ref_mem[a_lo] = wd[7:0];
            if (w0 < T && w1 < T) ref_mem[a_hi] = wd[15:8];
        end
        ref_rd = exp_rd;
    endtask

    task automatic invalid_op;
        int op;
        op = $urandom_range(0, 13);
        if (op >= 12) op += 2;
        i_start      = 1'b1;
        i_opcode     = 4'(op);
        i_address    = 16'($urandom);
        i_write_data = 16'($urandom);
        #1;
        chk("stall_badop", o_stall, 1'b0);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("req_badop", o_bus_req, 1'b0);
        chk("rd_badop", o_read_data, ref_rd);
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 9) == 0) return T;
        return $urandom_range(0, 3);
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 16'hFFFF;
            1:       return 16'h8003;   // aliases word 3 once bit 15 drops
            2:       return 16'h7FFF;
            default: return 16'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        n_total      = 0;
        n_bad        = 0;
        ref_rd       = 16'h0000;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_opcode     = 4'h0;
        i_address    = 16'h0000;
        i_write_data = 16'h0000;
        i_bus_rdata  = 8'h00;
        i_bus_ack    = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 8'($urandom);
            ref_mem[i] = bus_mem[i];
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_data", o_read_data, 16'h0000);
        chk("rst_done", o_done, 1'b0);
        chk("rst_bus_error", o_bus_error, 1'b0);
        chk("rst_bus_req", o_bus_req, 1'b0);
        chk("rst_bus_we", o_bus_we, 1'b0);
        chk("rst_bus_addr", o_bus_addr, 16'h0000);
        chk("rst_bus_wdata", o_bus_wdata, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed cases
        bus_mem[16'h000A] = 8'h34; ref_mem[16'h000A] = 8'h34;
        bus_mem[16'h000B] = 8'h12; ref_mem[16'h000B] = 8'h12;
        run_access(1'b0, 16'h0005, 16'h0000, 0, 0, 1'b0);
        run_access(1'b1, 16'h0010, 16'hBEEF, 0, 0, 1'b0);
        run_access(1'b0, 16'h0010, 16'h0000, 3, 0, 1'b0);
        run_access(1'b0, 16'h0005, 16'h0000, T, 0, 1'b0);
        invalid_op();
        run_access(1'b0, 16'h0005, 16'h0000, 0, 2, 1'b1);
        run_access(1'b1, 16'hFFFF, 16'hC3A5, 1, T, 1'b0);

        // randomized accesses
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) invalid_op();
            run_access(1'($urandom_range(0, 1)), pick_addr(), 16'($urandom),
                       pick_wait(), pick_wait(), 1'($urandom_range(0, 1)));
        end

        // reset while the second byte of a store is outstanding
        i_start      = 1'b1;
        i_opcode     = 4'b1101;
        i_address    = 16'h0003;
        i_write_data = 16'hA55A;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("mid_byte0_addr", o_bus_addr, 16'h0006);
        i_bus_ack = 1'b1;
        bus_mem[o_bus_addr] = o_bus_wdata;
        @(posedge clk); #1;
        i_bus_ack = 1'b0;
        chk("mid_byte1_req", o_bus_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", o_bus_req, 1'b0);
        chk("mid_rst_stall", o_stall, 1'b0);
        chk("mid_rst_rd", o_read_data, 16'h0000);
        ref_mem[16'h0006] = 8'h5A;
        ref_rd = 16'h0000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_req", o_bus_req, 1'b0);
        run_access(1'b0, 16'h0003, 16'h0000, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
